// File: rtl/real_time_down_counter.sv
// Prescaled countdown timer: load a value, decrement once per tick, pulse done at zero.
// Ticks come from an internal prescaler enable, so the whole block runs on a single clock.
module real_time_down_counter #(
  parameter int N           = 10,
  parameter int TICK_DIV    = 4,
  parameter bit AUTO_RELOAD = 1'b0,
  localparam int n          = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [n-1:0] i_load_data,
  input  logic         i_start,
  input  logic         i_pause,
  output logic [n-1:0] o_count,
  output logic         o_running,
  output logic         o_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [n-1:0]  MAX_CNT  = n'(N - 1);
  localparam logic [n-1:0]  ONE_CNT  = n'(1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  logic [n-1:0]  r_count;
  logic [n-1:0]  r_reload;
  logic [PW-1:0] r_presc;
  logic          r_running;
  logic          r_done;

  logic [n-1:0]  w_load_sat;
  logic          w_tick;

  always_comb begin
    w_load_sat = i_load_data;
    if (i_load_data > MAX_CNT) begin
      w_load_sat = MAX_CNT;
    end
  end

  assign w_tick = (r_presc == PRE_LAST);

  // A held pause blocks start in every state; in RUN it also freezes the prescaler.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_count   <= w_load_sat;
        r_reload  <= w_load_sat;
        r_presc   <= '0;
        r_state   <= S_IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!i_pause && i_start && (r_count != '0)) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
              r_presc   <= '0;
            end
          end
          S_RUN: begin
            if (i_pause) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end else if (w_tick) begin
              r_presc <= '0;
              if (r_count > ONE_CNT) begin
                r_count <= r_count - ONE_CNT;
              end else if (r_count == ONE_CNT) begin
                r_done <= 1'b1;
                if (AUTO_RELOAD) begin
                  r_count <= r_reload;
                end else begin
                  r_count   <= '0;
                  r_state   <= S_IDLE;
                  r_running <= 1'b0;
                end
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          S_PAUSE: begin
            if (!i_pause && i_start) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_count   = r_count;
  assign o_running = r_running;
  assign o_done    = r_done;

endmodule

// File: tb/tb_real_time_down_counter.sv
// Bench for real_time_down_counter: three configurations share one stimulus stream and are
// compared every cycle against an edges-until-tick reference model, plus directed scenarios.
module tb_real_time_down_counter;

  logic       clk;
  logic       r_reset;
  logic       r_load;
  logic [3:0] r_load_data;
  logic       r_start;
  logic       r_pause;

  logic [3:0] cnt_v [3];
  logic [2:0] run_v;
  logic [2:0] done_v;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  real_time_down_counter #(.N(10), .TICK_DIV(4), .AUTO_RELOAD(1'b0)) dut_a (
    .i_clk(clk), .i_reset(r_reset), .i_load(r_load), .i_load_data(r_load_data),
    .i_start(r_start), .i_pause(r_pause),
    .o_count(cnt_v[0]), .o_running(run_v[0]), .o_done(done_v[0]));

  real_time_down_counter #(.N(10), .TICK_DIV(4), .AUTO_RELOAD(1'b1)) dut_b (
    .i_clk(clk), .i_reset(r_reset), .i_load(r_load), .i_load_data(r_load_data),
    .i_start(r_start), .i_pause(r_pause),
    .o_count(cnt_v[1]), .o_running(run_v[1]), .o_done(done_v[1]));

  real_time_down_counter #(.N(10), .TICK_DIV(1), .AUTO_RELOAD(1'b0)) dut_c (
    .i_clk(clk), .i_reset(r_reset), .i_load(r_load), .i_load_data(r_load_data),
    .i_start(r_start), .i_pause(r_pause),
    .o_count(cnt_v[2]), .o_running(run_v[2]), .o_done(done_v[2]));

  // Reference model: remaining count, last loaded value, active/held flags and
  // the number of un-paused RUN edges still needed before the next decrement.
  int    cfg_div [3] = '{4, 4, 1};
  bit    cfg_ar  [3] = '{1'b0, 1'b1, 1'b0};
  string cfg_nm  [3] = '{"A", "B", "C"};
  int m_cnt  [3];
  int m_rl   [3];
  bit m_act  [3];
  bit m_held [3];
  int m_left [3];
  bit m_done [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k, input bit rst, input bit ld, input int ldv,
                            input bit st, input bit ps);
    m_done[k] = 1'b0;
    if (rst) begin
      m_cnt[k] = 0; m_rl[k] = 0; m_act[k] = 0; m_held[k] = 0; m_left[k] = cfg_div[k];
    end else if (ld) begin
      m_cnt[k]  = (ldv > 9) ? 9 : ldv;
      m_rl[k]   = m_cnt[k];
      m_act[k]  = 0;
      m_held[k] = 0;
      m_left[k] = cfg_div[k];
    end else if (m_act[k]) begin
      if (ps) begin
        m_act[k] = 0; m_held[k] = 1;
      end else begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_left[k] = cfg_div[k];
          if (m_cnt[k] > 1) m_cnt[k]--;
          else if (m_cnt[k] == 1) begin
            m_done[k] = 1'b1;
            if (cfg_ar[k]) m_cnt[k] = m_rl[k];
            else begin
              m_cnt[k] = 0; m_act[k] = 0;
            end
          end
        end
      end
    end else if (m_held[k]) begin
      if (st && !ps) begin
        m_act[k] = 1; m_held[k] = 0;
      end
    end else if (st && !ps && m_cnt[k] != 0) begin
      m_act[k] = 1; m_left[k] = cfg_div[k];
    end
  endtask

  task automatic step(input bit rst, input bit ld, input int ldv, input bit st, input bit ps);
    r_reset = rst; r_load = ld; r_load_data = ldv[3:0]; r_start = st; r_pause = ps;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, rst, ld, ldv, st, ps);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk({cfg_nm[k], ".count"},   32'(cnt_v[k]),  32'(m_cnt[k]));
      chk({cfg_nm[k], ".running"}, 32'(run_v[k]),  32'(m_act[k]));
      chk({cfg_nm[k], ".done"},    32'(done_v[k]), 32'(m_done[k]));
    end
    r_reset = 0; r_load = 0; r_start = 0; r_pause = 0;
  endtask

  initial begin
    r_reset = 1; r_load = 0; r_load_data = '0; r_start = 0; r_pause = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_count", 32'(cnt_v[0]), 32'd0);
    chk("reset_done",  32'(done_v[0]), 32'd0);

    // Reset held two cycles in the middle of a countdown.
    step(0, 1, 5, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int e = 0; e < 6; e++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_mid_count", 32'(cnt_v[0]), 32'd0);
    chk("rst_mid_run",   32'(run_v[0]), 32'd0);
    chk("rst_mid_done",  32'(done_v[0]), 32'd0);

    // Load 3 and start: decrements land on S+4, S+8, S+12.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int e = 1; e <= 13; e++) begin
      step(0, 0, 0, 0, 0);
      if (e == 4)  chk("t2_cnt_s4", 32'(cnt_v[0]), 32'd2);
      if (e == 8)  chk("t2_cnt_s8", 32'(cnt_v[0]), 32'd1);
      if (e == 12) begin
        chk("t2_cnt_s12",  32'(cnt_v[0]),  32'd0);
        chk("t2_done_s12", 32'(done_v[0]), 32'd1);
        chk("t2_run_s12",  32'(run_v[0]),  32'd0);
      end
      if (e == 13) chk("t2_done_s13", 32'(done_v[0]), 32'd0);
    end

    // Saturating load, then a zero count that must not start.
    step(0, 1, 12, 0, 0);
    chk("t3_sat", 32'(cnt_v[0]), 32'd9);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t3_zero_run", 32'(run_v[0]), 32'd0);
    for (int e = 0; e < 5; e++) step(0, 0, 0, 0, 0);

    // Pause at S+6 for 10 edges, resume at S+16, expiry at S+23.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int e = 1; e <= 24; e++) begin
      step(0, 0, 0, (e == 16), (e == 6));
      if (e == 10) begin
        chk("t4_held_cnt", 32'(cnt_v[0]), 32'd2);
        chk("t4_held_run", 32'(run_v[0]), 32'd0);
      end
      if (e == 22) chk("t4_cnt_s22", 32'(cnt_v[0]), 32'd1);
      if (e == 23) chk("t4_done_s23", 32'(done_v[0]), 32'd1);
      if (e == 24) chk("t4_done_s24", 32'(done_v[0]), 32'd0);
    end

    // Auto-reload instance: load 2 cycles 2,1,2,1 with done every 8 edges.
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int e = 1; e <= 32; e++) begin
      step(0, 0, 0, 0, 0);
      chk("t5_cnt",  32'(cnt_v[1]),  ((e % 8) >= 4) ? 32'd1 : 32'd2);
      chk("t5_done", 32'(done_v[1]), ((e % 8) == 0) ? 32'd1 : 32'd0);
      chk("t5_run",  32'(run_v[1]),  32'd1);
    end

    // Load during RUN, then pause+start on the same edge.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int e = 0; e < 4; e++) step(0, 0, 0, 0, 0);
    chk("t6_pre_cnt", 32'(cnt_v[0]), 32'd2);
    step(0, 1, 5, 0, 0);
    chk("t6_ld_cnt", 32'(cnt_v[0]), 32'd5);
    chk("t6_ld_run", 32'(run_v[0]), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("t6_ps_idle", 32'(run_v[0]), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("t6_start", 32'(run_v[0]), 32'd1);
    step(0, 0, 0, 1, 1);
    chk("t6_ps_run", 32'(run_v[0]), 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit rst, ld, st, ps;
      int ldv;
      rst = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      ldv = $urandom_range(0, 15);
      st  = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 11) == 0);
      step(rst, ld, ldv, st, ps);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
